// File: rtl/ospi_ddr_tx.sv
// OSPI transmit DDR sequencer: a {last, data} word FIFO feeding a chip-select framing FSM
// that drives the pad ODDR cells. Define OSPI_DDR_TX_MASK_EN to carry a 2-bit RWDS mask per word.
module ospi_ddr_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CSS_CYCLES = 1,
    parameter int CSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_last,
`ifdef OSPI_DDR_TX_MASK_EN
    input  logic [1:0]  s_mask,
    output logic        rwds_dp_o,
    output logic        rwds_dn_o,
`endif
    output logic [7:0]  dp_o,
    output logic [7:0]  dn_o,
    output logic        oe_o,
    output logic        sclk_en_o,
    output logic        cs_n_o,
    output logic        busy_o,
    output logic        underrun_o
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CMAX = (CSS_CYCLES > CSH_CYCLES) ? CSS_CYCLES : CSH_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
`ifdef OSPI_DDR_TX_MASK_EN
    localparam int EW   = 19;
`else
    localparam int EW   = 17;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    // FIFO storage and bookkeeping
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CNTW-1:0] count_reg;
    logic [CNTW-1:0] count_next;
    logic            s_ready_reg;
    logic            push;
    logic            pop;
    logic            fifo_nonempty;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   head;

    // Framing FSM
    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic            last_reg;
    logic            last_next;
    logic            oe_reg;
    logic            oe_next;
    logic            sclk_en_reg;
    logic            sclk_en_next;
    logic            cs_n_reg;
    logic            cs_n_next;
    logic            busy_reg;
    logic            busy_next;
    logic            underrun_reg;
    logic            underrun_next;
    logic [7:0]      dp_reg;
    logic [7:0]      dn_reg;
    logic            load_word;
    logic            clr_word;

`ifdef OSPI_DDR_TX_MASK_EN
    assign wr_entry = {s_last, s_mask, s_data};
`else
    assign wr_entry = {s_last, s_data};
`endif

    assign push          = s_valid && s_ready_reg;
    assign fifo_nonempty = (count_reg != '0);
    assign head          = mem[rd_ptr_reg];
    assign count_next    = count_reg + CNTW'(push) - CNTW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    // s_ready is registered from the post-edge occupancy, so a pop at full only
    // frees a slot for the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            s_ready_reg <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg   <= count_next;
            s_ready_reg <= (count_next != CNTW'(FIFO_DEPTH));
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        last_next     = last_reg;
        oe_next       = oe_reg;
        sclk_en_next  = 1'b0;
        cs_n_next     = cs_n_reg;
        underrun_next = underrun_reg;
        pop           = 1'b0;
        load_word     = 1'b0;
        clr_word      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (fifo_nonempty) begin
                    state_next    = SETUP;
                    cnt_next      = CW'(CSS_CYCLES - 1);
                    cs_n_next     = 1'b0;
                    underrun_next = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    pop        = 1'b1;
                    load_word  = 1'b1;
                    state_next = XFER;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            XFER: begin
                // A stall only follows a non-last word, so last_reg alone decides HOLD.
                if (last_reg) begin
                    state_next = HOLD;
                    clr_word   = 1'b1;
                    cnt_next   = CW'(CSH_CYCLES - 1);
                end else if (fifo_nonempty) begin
                    pop       = 1'b1;
                    load_word = 1'b1;
                end else begin
                    underrun_next = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    cs_n_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cs_n_next  = 1'b1;
            end
        endcase

        if (load_word) begin
            last_next    = head[EW-1];
            oe_next      = 1'b1;
            sclk_en_next = 1'b1;
        end
        if (clr_word) begin
            last_next = 1'b0;
            oe_next   = 1'b0;
        end
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            last_reg     <= 1'b0;
            oe_reg       <= 1'b0;
            sclk_en_reg  <= 1'b0;
            cs_n_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            underrun_reg <= 1'b0;
            dp_reg       <= '0;
            dn_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            last_reg     <= last_next;
            oe_reg       <= oe_next;
            sclk_en_reg  <= sclk_en_next;
            cs_n_reg     <= cs_n_next;
            busy_reg     <= busy_next;
            underrun_reg <= underrun_next;
            if (load_word) begin
                dp_reg <= head[15:8];
                dn_reg <= head[7:0];
            end else if (clr_word) begin
                dp_reg <= '0;
                dn_reg <= '0;
            end
        end
    end

`ifdef OSPI_DDR_TX_MASK_EN
    logic rwds_dp_reg;
    logic rwds_dn_reg;

    // Mask bits ride with the data byte pair and share its load/clear/hold behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            rwds_dp_reg <= 1'b0;
            rwds_dn_reg <= 1'b0;
        end else if (load_word) begin
            rwds_dp_reg <= head[17];
            rwds_dn_reg <= head[16];
        end else if (clr_word) begin
            rwds_dp_reg <= 1'b0;
            rwds_dn_reg <= 1'b0;
        end
    end

    assign rwds_dp_o = rwds_dp_reg;
    assign rwds_dn_o = rwds_dn_reg;
`endif

    assign s_ready    = s_ready_reg;
    assign dp_o       = dp_reg;
    assign dn_o       = dn_reg;
    assign oe_o       = oe_reg;
    assign sclk_en_o  = sclk_en_reg;
    assign cs_n_o     = cs_n_reg;
    assign busy_o     = busy_reg;
    assign underrun_o = underrun_reg;

endmodule

// File: tb/tb_ospi_ddr_tx.sv
// Bench for ospi_ddr_tx: accepted words go into a scoreboard queue; a negedge monitor pops
// and checks every word the DUT presents, plus directed framing/underrun/full/reset checks.
module tb_ospi_ddr_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic [7:0]  dp_o;
    logic [7:0]  dn_o;
    logic        oe_o;
    logic        sclk_en_o;
    logic        cs_n_o;
    logic        busy_o;
    logic        underrun_o;
`ifdef OSPI_DDR_TX_MASK_EN
    logic [1:0]  s_mask;
    logic        rwds_dp_o;
    logic        rwds_dn_o;
`endif

    always #5 clk = ~clk;

    ospi_ddr_tx #(
        .FIFO_DEPTH(4),
        .CSS_CYCLES(1),
        .CSH_CYCLES(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
`ifdef OSPI_DDR_TX_MASK_EN
        .s_mask     (s_mask),
        .rwds_dp_o  (rwds_dp_o),
        .rwds_dn_o  (rwds_dn_o),
`endif
        .dp_o       (dp_o),
        .dn_o       (dn_o),
        .oe_o       (oe_o),
        .sclk_en_o  (sclk_en_o),
        .cs_n_o     (cs_n_o),
        .busy_o     (busy_o),
        .underrun_o (underrun_o)
    );

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [1:0]  mask;
    } word_t;

    word_t exp_q[$];
    word_t mon_w;
    int    tests = 0;
    int    fails = 0;
    bit    hold_expect = 1'b0;
    int    run_cur = 0;
    int    run_last = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Drives one word and waits for the handshake; the expected output is queued on acceptance.
    task automatic send_word(input logic [15:0] d, input logic l, input logic [1:0] m, output int waits);
        word_t w;
        bit    ok;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
`ifdef OSPI_DDR_TX_MASK_EN
        s_mask  = m;
`endif
        waits = 0;
        ok    = 1'b0;
        while (!ok && waits <= 200) begin
            ok = s_ready;
            @(posedge clk);
            #1;
            if (!ok) waits++;
        end
        if (ok) begin
            w.data = d;
            w.last = l;
            w.mask = m;
            exp_q.push_back(w);
            $display("[TB] in  0x%04h last=%0d mask=%0d", d, l, m);
        end else begin
            chk("send_accept_timeout", 32'(ok), 32'd1);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (!busy_o && exp_q.size() == 0) done = 1'b1;
        end
        chk("idle_reached", 32'(done), 32'd1);
    endtask

    // Monitor: every presented word must match the queue head; a last word is followed by HOLD.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            hold_expect = 1'b0;
            run_cur     = 0;
        end else begin
            if (hold_expect) begin
                chk("hold_oe", 32'(oe_o), 32'd0);
                chk("hold_sclk_en", 32'(sclk_en_o), 32'd0);
                chk("hold_cs_n", 32'(cs_n_o), 32'd0);
                chk("hold_data", {16'd0, dp_o, dn_o}, 32'd0);
`ifdef OSPI_DDR_TX_MASK_EN
                chk("hold_rwds", {30'd0, rwds_dp_o, rwds_dn_o}, 32'd0);
`endif
                hold_expect = 1'b0;
            end
            if (sclk_en_o) begin
                run_cur++;
                chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_w = exp_q.pop_front();
                    $display("[TB] out 0x%02h%02h last=%0d", dp_o, dn_o, mon_w.last);
                    chk("word_data", {16'd0, dp_o, dn_o}, {16'd0, mon_w.data});
                    chk("word_oe", 32'(oe_o), 32'd1);
                    chk("word_cs_n", 32'(cs_n_o), 32'd0);
`ifdef OSPI_DDR_TX_MASK_EN
                    chk("word_rwds", {30'd0, rwds_dp_o, rwds_dn_o}, {30'd0, mon_w.mask});
`endif
                    hold_expect = mon_w.last;
                end
            end else if (run_cur > 0) begin
                run_last = run_cur;
                run_cur  = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          w4;
        int          wsum;
        int          len;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
`ifdef OSPI_DDR_TX_MASK_EN
        s_mask  = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dp", 32'(dp_o), 32'd0);
        chk("rst_dn", 32'(dn_o), 32'd0);
        chk("rst_oe", 32'(oe_o), 32'd0);
        chk("rst_sclk_en", 32'(sclk_en_o), 32'd0);
        chk("rst_cs_n", 32'(cs_n_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_underrun", 32'(underrun_o), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
`ifdef OSPI_DDR_TX_MASK_EN
        chk("rst_rwds", {30'd0, rwds_dp_o, rwds_dn_o}, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Single word: accepted at e0, SETUP after e1, data after e2, HOLD after e3, IDLE after e4.
        send_word(16'hA55A, 1'b1, 2'b10, w);
        s_valid = 1'b0;
        @(negedge clk);
        chk("t1_cs_n_e0", 32'(cs_n_o), 32'd1);
        @(negedge clk);
        chk("t1_cs_n_setup", 32'(cs_n_o), 32'd0);
        chk("t1_oe_setup", 32'(oe_o), 32'd0);
        @(negedge clk);
        chk("t1_oe_data", 32'(oe_o), 32'd1);
        chk("t1_sclk_data", 32'(sclk_en_o), 32'd1);
        chk("t1_dp", 32'(dp_o), 32'hA5);
        chk("t1_dn", 32'(dn_o), 32'h5A);
`ifdef OSPI_DDR_TX_MASK_EN
        chk("t1_rwds_dp", 32'(rwds_dp_o), 32'd1);
        chk("t1_rwds_dn", 32'(rwds_dn_o), 32'd0);
`endif
        @(negedge clk);
        chk("t1_cs_n_hold", 32'(cs_n_o), 32'd0);
        chk("t1_oe_hold", 32'(oe_o), 32'd0);
        @(negedge clk);
        chk("t1_cs_n_idle", 32'(cs_n_o), 32'd1);
        chk("t1_busy_idle", 32'(busy_o), 32'd0);
        chk("t1_run_len", 32'(run_last), 32'd1);
        wait_idle();

        // Back-to-back four-word frame.
        wsum = 0;
        for (int i = 0; i < 4; i++) begin
            send_word(16'h0102 + 16'(i) * 16'h0202, i == 3, 2'b00, w);
            wsum += w;
        end
        s_valid = 1'b0;
        chk("t2_no_backpressure", 32'(wsum), 32'd0);
        wait_idle();
        chk("t2_run_len", 32'(run_last), 32'd4);
        chk("t2_no_underrun", 32'(underrun_o), 32'd0);

        // Underrun: two words, three idle edges, then the last word.
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        send_word(d0, 1'b0, 2'b01, w);
        send_word(d1, 1'b0, 2'b11, w);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t3_stall_sclk", 32'(sclk_en_o), 32'd0);
        chk("t3_stall_oe", 32'(oe_o), 32'd1);
        chk("t3_stall_cs_n", 32'(cs_n_o), 32'd0);
        chk("t3_stall_data", {16'd0, dp_o, dn_o}, {16'd0, d1});
        chk("t3_underrun_set", 32'(underrun_o), 32'd1);
        send_word(d2, 1'b1, 2'b10, w);
        s_valid = 1'b0;
        @(negedge clk);
        chk("t3_stall2_sclk", 32'(sclk_en_o), 32'd0);
        chk("t3_stall2_data", {16'd0, dp_o, dn_o}, {16'd0, d1});
        @(negedge clk);
        @(negedge clk);
        chk("t3_underrun_hold", 32'(underrun_o), 32'd1);
        wait_idle();
        chk("t3_underrun_sticky_idle", 32'(underrun_o), 32'd1);

        // Full FIFO: a one-word frame, then six words held valid across its HOLD/IDLE/SETUP.
        send_word(16'($urandom), 1'b1, 2'b00, w);
        send_word(16'($urandom), 1'b0, 2'b01, w);
        chk("t4_underrun_cleared", 32'(underrun_o), 32'd0);
        send_word(16'($urandom), 1'b0, 2'b10, w);
        send_word(16'($urandom), 1'b0, 2'b11, w);
        send_word(16'($urandom), 1'b0, 2'b00, w);
        chk("t4_full_not_ready", 32'(s_ready), 32'd0);
        send_word(16'($urandom), 1'b0, 2'b01, w4);
        chk("t4_full_wait", 32'(w4), 32'd2);
        send_word(16'($urandom), 1'b1, 2'b10, w);
        s_valid = 1'b0;
        wait_idle();
        chk("t4_run_len", 32'(run_last), 32'd6);

        // Reset while word 2 of 4 is stalled and word 3 sits in the FIFO.
        send_word(16'($urandom), 1'b0, 2'b00, w);
        send_word(16'($urandom), 1'b0, 2'b00, w);
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_underrun_before", 32'(underrun_o), 32'd1);
        send_word(16'($urandom), 1'b0, 2'b00, w);
        s_valid = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("t5_cs_n", 32'(cs_n_o), 32'd1);
        chk("t5_oe", 32'(oe_o), 32'd0);
        chk("t5_sclk_en", 32'(sclk_en_o), 32'd0);
        chk("t5_underrun", 32'(underrun_o), 32'd0);
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_s_ready", 32'(s_ready), 32'd1);
        chk("t5_data", {16'd0, dp_o, dn_o}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_fifo_flushed", 32'(busy_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send_word(16'($urandom), i == 2, 2'($urandom_range(0, 3)), w);
        end
        s_valid = 1'b0;
        wait_idle();

        // Randomized frames with random intra-frame gaps (forcing underruns) and inter-frame gaps.
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                send_word(16'($urandom), i == len - 1, 2'($urandom_range(0, 3)), w);
                if ($urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        chk("all_words_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
